adc_avg_fifo: RTL and testbench

Downstream consumer of the ADC serial controller's 12-bit conversion results. Accepts one tagged sample per strobe, averages 2^AVG_LOG2 consecutive samples per channel (8 independent accumulators), and queues each finished average in a show-ahead FIFO. The FIFO is read by the logger/transport stage. Drops are counted and flagged, never silent.

---
 rtl/adc_log_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/adc_avg_fifo.sv | 125 ++++++++++++
 tb/tb_adc_avg_fifo.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_log_pkg.sv
// Shared types and constants for the ADC averaging/logging path.
// The packed word layout is what the logger/transport stage reads out of the FIFO.
package adc_log_pkg;

  localparam int SAMPLE_W = 12;
  localparam int CH_W     = 3;
  localparam int NUM_CH   = 8;
  localparam int SUM_W    = SAMPLE_W + 4;

  typedef struct packed {
    logic                lost;
    logic [CH_W-1:0]     ch;
    logic [SAMPLE_W-1:0] avg;
  } adc_word_t;

  // Truncating divide by 2^log2; no rounding.
  function automatic logic [SAMPLE_W-1:0] avg_shift(input logic [SUM_W-1:0] sum,
                                                    input int unsigned log2);
    logic [SUM_W-1:0] shifted;
    shifted   = sum >> log2;
    avg_shift = shifted[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with registered full/empty/count.
// The head word reads as zero while empty so the output is clean after reset.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;
  logic [AW:0]      count_nxt;

  assign pop_ok  = pop & ~empty;
  // A push into a full FIFO is legal when the head leaves in the same edge.
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    count_nxt = count;
    if (push_ok & ~pop_ok)
      count_nxt = count + 1'b1;
    else if (pop_ok & ~push_ok)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge iCLK) begin
    if (push_ok)
      mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/adc_avg_fifo.sv
// Per-channel block averager for ADC samples feeding a show-ahead log FIFO.
// Averages that find the FIFO full are counted, flagged, and marked on the next stored word.
module adc_avg_fifo
  import adc_log_pkg::*;
#(
  parameter int AVG_LOG2 = 2,
  parameter int DEPTH    = 16
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iENABLE,
  input  logic                     iVALID,
  input  logic [2:0]               iCH,
  input  logic [11:0]              iDATA,
  input  logic                     iRD_EN,
  input  logic                     iCLR_OVF,
  output logic [15:0]              oRD_DATA,
  output logic                     oEMPTY,
  output logic                     oFULL,
  output logic [$clog2(DEPTH):0]   oCOUNT,
  output logic                     oOVF,
  output logic [7:0]               oDROP_CNT
);

  localparam int ACC_W = SAMPLE_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]    acc [NUM_CH];
  logic [CNT_W-1:0]    cnt [NUM_CH];
  logic                accept_p0;
  logic                done_p0;
  logic [ACC_W-1:0]    sum_p0;
  logic                push_vld_p1;
  logic [CH_W-1:0]     push_ch_p1;
  logic [SAMPLE_W-1:0] push_avg_p1;
  logic                lost_pend;
  logic                drop;
  adc_word_t           wr_word;

  assign accept_p0 = iVALID & iENABLE;
  assign sum_p0    = acc[iCH] + ACC_W'(iDATA);
  assign done_p0   = (cnt[iCH] == CNT_LAST);

  // Stage p0 -> p1: accumulate, and register a push request on block completion
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c] <= '0;
        cnt[c] <= '0;
      end
      push_vld_p1 <= 1'b0;
      push_ch_p1  <= '0;
      push_avg_p1 <= '0;
    end else begin
      if (!iENABLE) begin
        for (int c = 0; c < NUM_CH; c++) begin
          acc[c] <= '0;
          cnt[c] <= '0;
        end
      end else if (iVALID) begin
        if (done_p0) begin
          acc[iCH] <= '0;
          cnt[iCH] <= '0;
        end else begin
          acc[iCH] <= sum_p0;
          cnt[iCH] <= cnt[iCH] + 1'b1;
        end
      end
      push_vld_p1 <= accept_p0 & done_p0;
      if (accept_p0 & done_p0) begin
        push_ch_p1  <= iCH;
        push_avg_p1 <= avg_shift(SUM_W'(sum_p0), AVG_LOG2);
      end
    end
  end

  // Stage p1 -> FIFO: store or drop the pending average
  assign drop = push_vld_p1 & oFULL & ~iRD_EN;

  always_comb begin
    wr_word      = '0;
    wr_word.lost = lost_pend;
    wr_word.ch   = push_ch_p1;
    wr_word.avg  = push_avg_p1;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      lost_pend <= 1'b0;
      oOVF      <= 1'b0;
      oDROP_CNT <= '0;
    end else begin
      if (drop)
        lost_pend <= 1'b1;
      else if (push_vld_p1)
        lost_pend <= 1'b0;
      // Clearing wins over a coincident drop; lost_pend is left alone.
      if (iCLR_OVF) begin
        oOVF      <= 1'b0;
        oDROP_CNT <= '0;
      end else if (drop) begin
        oOVF <= 1'b1;
        if (oDROP_CNT != 8'hFF)
          oDROP_CNT <= oDROP_CNT + 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH ($bits(adc_word_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .push  (push_vld_p1),
    .pop   (iRD_EN),
    .wdata (wr_word),
    .rdata (oRD_DATA),
    .full  (oFULL),
    .empty (oEMPTY),
    .count (oCOUNT)
  );

endmodule

// File: tb/tb_adc_avg_fifo.sv
// Bench for adc_avg_fifo: one averaging instance (AVG_LOG2=2, DEPTH=16) and one
// pass-through instance (AVG_LOG2=0, DEPTH=4); popped words are checked against queues.
module tb_adc_avg_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_en, a_vld, a_rd, a_clr;
  logic [2:0]  a_ch;
  logic [11:0] a_data;
  logic [15:0] a_rdata;
  logic        a_empty, a_full, a_ovf;
  logic [4:0]  a_count;
  logic [7:0]  a_drop;

  logic        b_rst, b_en, b_vld, b_rd, b_clr;
  logic [2:0]  b_ch;
  logic [11:0] b_data;
  logic [15:0] b_rdata;
  logic        b_empty, b_full, b_ovf;
  logic [2:0]  b_count;
  logic [7:0]  b_drop;

  adc_avg_fifo #(.AVG_LOG2(2), .DEPTH(16)) dut_a (
    .iCLK(clk), .iRST(a_rst), .iENABLE(a_en), .iVALID(a_vld), .iCH(a_ch), .iDATA(a_data),
    .iRD_EN(a_rd), .iCLR_OVF(a_clr), .oRD_DATA(a_rdata), .oEMPTY(a_empty), .oFULL(a_full),
    .oCOUNT(a_count), .oOVF(a_ovf), .oDROP_CNT(a_drop));

  adc_avg_fifo #(.AVG_LOG2(0), .DEPTH(4)) dut_b (
    .iCLK(clk), .iRST(b_rst), .iENABLE(b_en), .iVALID(b_vld), .iCH(b_ch), .iDATA(b_data),
    .iRD_EN(b_rd), .iCLR_OVF(b_clr), .oRD_DATA(b_rdata), .oEMPTY(b_empty), .oFULL(b_full),
    .oCOUNT(b_count), .oOVF(b_ovf), .oDROP_CNT(b_drop));

  int tests = 0;
  int fails = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] word(input logic lost, input logic [2:0] ch, input logic [11:0] avg);
    return {lost, ch, avg};
  endfunction

  // Monitor: every accepted pop is compared against the oldest expected word.
  always @(negedge clk) begin
    if (a_rd && !a_empty) begin
      if (qa.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_pop: got %h, expected no entry", a_rdata);
      end else chk("a_pop", a_rdata, qa.pop_front());
    end
    if (b_rd && !b_empty) begin
      if (qb.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_pop: got %h, expected no entry", b_rdata);
      end else chk("b_pop", b_rdata, qb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic a_smp(input logic [2:0] ch, input logic [11:0] d);
    a_vld = 1'b1; a_ch = ch; a_data = d;
    tick();
    a_vld = 1'b0;
  endtask

  task automatic b_smp(input logic [2:0] ch, input logic [11:0] d);
    b_vld = 1'b1; b_ch = ch; b_data = d;
    tick();
    b_vld = 1'b0;
  endtask

  task automatic a_pop();
    a_rd = 1'b1; tick(); a_rd = 1'b0;
  endtask

  task automatic b_pop();
    b_rd = 1'b1; tick(); b_rd = 1'b0;
  endtask

  initial begin
    a_rst = 0; a_en = 1; a_vld = 0; a_rd = 0; a_clr = 0; a_ch = 0; a_data = 0;
    b_rst = 0; b_en = 1; b_vld = 0; b_rd = 0; b_clr = 0; b_ch = 0; b_data = 0;
    repeat (3) tick();
    a_rst = 1; b_rst = 1;
    tick();

    // Reset state
    chk("rst_a_empty", a_empty, 1);
    chk("rst_a_full", a_full, 0);
    chk("rst_a_count", a_count, 0);
    chk("rst_a_ovf", a_ovf, 0);
    chk("rst_a_drop", a_drop, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_empty", b_empty, 1);
    chk("rst_b_count", b_count, 0);

    // ch3 100..103 -> avg 101, visible two edges after the 4th strobe
    a_smp(3, 100); a_smp(3, 101); a_smp(3, 102);
    tick(); tick();
    chk("avg_no_early", a_empty, 1);
    qa.push_back(word(0, 3, 101));
    a_smp(3, 103);
    chk("avg_lat1", a_empty, 1);
    tick();
    chk("avg_lat2", a_empty, 0);
    chk("avg_count", a_count, 1);
    a_pop();
    chk("avg_popped_empty", a_empty, 1);

    // Interleaved ch0 / ch7
    qa.push_back(word(0, 0, 12'hFFF));
    qa.push_back(word(0, 7, 12'h001));
    for (int i = 0; i < 8; i++) a_smp((i % 2) ? 3'd7 : 3'd0, (i % 2) ? 12'h001 : 12'hFFF);
    tick(); tick();
    chk("ilv_count", a_count, 2);
    a_pop(); a_pop();

    // Enable low discards the partial ch1 block
    a_smp(1, 12'h100); a_smp(1, 12'h100);
    a_en = 0; tick(); a_en = 1;
    qa.push_back(word(0, 1, 25));
    a_smp(1, 10); a_smp(1, 20); a_smp(1, 30); a_smp(1, 40);
    tick(); tick();
    chk("en_count", a_count, 1);
    a_pop();

    // Reset with three entries and a partial ch5 block
    for (int i = 0; i < 12; i++) a_smp(2, 12'h222);
    a_smp(5, 12'hFFF); a_smp(5, 12'hFFF);
    tick(); tick();
    chk("prerst_count", a_count, 3);
    #2 a_rst = 0;
    #1;
    chk("midrst_empty", a_empty, 1);
    chk("midrst_count", a_count, 0);
    chk("midrst_ovf", a_ovf, 0);
    tick();
    a_rst = 1;
    qa.delete();
    tick();
    qa.push_back(word(0, 5, 8));
    for (int i = 0; i < 4; i++) a_smp(5, 8);
    tick(); tick();
    chk("postrst_count", a_count, 1);
    a_pop();

    // Pass-through instance: six samples into four slots
    for (int i = 0; i < 6; i++) begin
      if (i < 4) qb.push_back(word(0, 3'(i), 12'(i + 1)));
      b_smp(3'(i), 12'(i + 1));
    end
    tick(); tick();
    chk("ovf_full", b_full, 1);
    chk("ovf_count", b_count, 4);
    chk("ovf_flag", b_ovf, 1);
    chk("ovf_drop", b_drop, 2);
    b_pop();
    qb.push_back(word(1, 6, 7));
    b_smp(6, 7);
    tick(); tick();
    chk("lost_refill_count", b_count, 4);
    b_clr = 1; tick(); b_clr = 0;
    chk("clr_ovf", b_ovf, 0);
    chk("clr_drop", b_drop, 0);

    // Push while full with a same-cycle pop: no drop
    qb.push_back(word(0, 2, 12'h123));
    b_smp(2, 12'h123);
    b_rd = 1; tick(); b_rd = 0;
    chk("fullrw_count", b_count, 4);
    chk("fullrw_ovf", b_ovf, 0);
    chk("fullrw_drop", b_drop, 0);

    // Clear coincident with a drop wins
    b_smp(1, 9);
    b_clr = 1; tick(); b_clr = 0;
    chk("clrprio_ovf", b_ovf, 0);
    chk("clrprio_drop", b_drop, 0);

    // Drop counter saturates
    for (int i = 0; i < 260; i++) b_smp(0, 0);
    tick(); tick();
    chk("sat_drop", b_drop, 8'hFF);
    chk("sat_ovf", b_ovf, 1);
    b_clr = 1; tick(); b_clr = 0;

    // Drain, then lost-pending marks the next stored word
    for (int i = 0; i < 4; i++) b_pop();
    chk("drain_empty", b_empty, 1);
    chk("drain_count", b_count, 0);
    qb.push_back(word(1, 4, 12'h055));
    b_smp(4, 12'h055);
    tick(); tick();
    b_pop();
    tick();

    chk("qa_drained", 16'(qa.size()), 0);
    chk("qb_drained", 16'(qb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
